cakegame_uc: RTL and testbench
==============================

Name: cakegame_uc

Overview:
- Moore control unit for the cake-game datapath.
- Sequences one round per memory address: show the stored pattern, wait for a button play, register it, compare it, then score and advance, or end the game.
- Latches the difficulty selection at game start.
- Reports won/lost/done and the state code to the top level.

Parameters:
none (state codes live in the shared package)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; returns FSM to IDLE on next rising edge
- start  in  1  level; begins a game from IDLE, WON or LOST
- mode_sw  in  1  difficulty switch, sampled only in IDLE/WON/LOST when start=1
- end_mem_counter  in  1  datapath: address counter at last entry (15)
- correct_play  in  1  datapath: registered play equals memory output
- has_play  in  1  datapath: one-cycle button-press pulse
- end_show  in  1  datapath: show timer terminal count
- half_show  in  1  datapath: show timer midpoint
- timeout  in  1  datapath: play-wait timer terminal count
- out_sel  out  2  0=blank, 1=memory pattern, 2=live buttons
- dificuldade  out  1  latched difficulty (memory select)
- clear_reg, enable_reg  out  1 each  play register / edge-detector control
- clear_mem_counter, enable_mem_counter  out  1 each
- clear_show_counter, enable_show_counter  out  1 each
- enable_timeout_counter  out  1
- clear_points_counter, enable_points_counter  out  1 each
- won, lost, done  out  1 each  game-result levels
- db_estado  out  4  current state code

Behaviour:
- One 4-bit state register. All outputs decode from state only (Moore). Outputs change one cycle after the triggering input.
- Reset:
  - state=IDLE, dificuldade=0.
  - All outputs read IDLE values: every clear/enable 0, out_sel=0, won=lost=done=0.
- Any output not listed for a state is 0.
- States (code: outputs; transitions):
  - IDLE(0): out_sel=0. start -> INIT, latch dificuldade<=mode_sw.
  - INIT(1): clear_reg, clear_mem_counter, clear_show_counter, clear_points_counter=1. -> SHOW.
  - SHOW(2): out_sel=1, enable_show_counter=1. end_show -> WAIT_PLAY; else half_show -> SHOW_GAP.
  - SHOW_GAP(3): out_sel=0, enable_show_counter=1. end_show -> WAIT_PLAY.
  - WAIT_PLAY(4): out_sel=2, enable_timeout_counter=1. has_play -> REGISTER; else timeout -> LOST. has_play wins on a simultaneous event.
  - REGISTER(5): out_sel=2, enable_reg=1. -> COMPARE.
  - COMPARE(6): out_sel=2.
    - correct_play & end_mem_counter -> WON
    - correct_play & ~end_mem_counter -> NEXT
    - ~correct_play -> LOST
  - NEXT(7): enable_points_counter, enable_mem_counter, clear_show_counter, clear_reg=1. -> SHOW.
  - WON(8): won=1, done=1, out_sel=0. start -> INIT, relatching dificuldade.
  - LOST(9): lost=1, done=1, out_sel=0. start -> INIT, relatching dificuldade.
  - Codes 10-15: illegal; -> IDLE next cycle, outputs as IDLE.
- dificuldade is held constant from INIT until the next accepted start. mode_sw changes mid-game are ignored.
- enable_timeout_counter is 1 only in WAIT_PLAY, so the timer restarts from 0 on every entry.
- The final correct round (address 15) is not scored; a full win reads points=15 with won=1.
- start held high through WON/LOST causes an immediate restart. The top level must pulse start.
- reset has priority over all transitions, including mid-round. Datapath counters are cleared only by the next INIT.
- Minimum round: SHOW..NEXT = show time + 4 cycles after has_play.

Decomposition:
- Package cakegame_pkg holds the 4-bit state localparams:
  - IDLE=0, INIT=1, SHOW=2, SHOW_GAP=3, WAIT_PLAY=4
  - REGISTER=5, COMPARE=6, NEXT=7, WON=8, LOST=9
  - OUT_BLANK=0, OUT_MEM=1, OUT_BTN=2
- No sub-module: next-state logic, state register, difficulty latch and output decoder all live in a single module.

Test Plan:
- Reset then start=1, mode_sw=1 for 1 cycle -> db_estado 0->1->2; dificuldade=1; INIT asserts all four clears for exactly 1 cycle.
- In SHOW: half_show pulse -> SHOW_GAP with out_sel=0; then end_show -> WAIT_PLAY with out_sel=2 and enable_timeout_counter=1.
- In WAIT_PLAY: has_play, then correct_play=1, end_mem_counter=0 -> states 5,6,7,2; enable_points_counter and enable_mem_counter high exactly 1 cycle, in NEXT.
- In WAIT_PLAY: has_play and timeout in the same cycle -> REGISTER. In a separate run, timeout alone -> LOST with lost=1, done=1, held until start.
- In COMPARE: correct_play=1, end_mem_counter=1 -> WON, won=1; no enable_points_counter pulse. Then start=1 with mode_sw=0 -> INIT, dificuldade=0.
- Assert reset while in WAIT_PLAY -> IDLE next edge, all outputs 0. mode_sw toggled mid-game -> dificuldade unchanged.

Source files
------------

// File: rtl/cakegame_pkg.sv
// Shared state codes and output-select encodings for the cake-game control unit.
package cakegame_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT      = 4'd1,
        SHOW      = 4'd2,
        SHOW_GAP  = 4'd3,
        WAIT_PLAY = 4'd4,
        REGISTER  = 4'd5,
        COMPARE   = 4'd6,
        NEXT      = 4'd7,
        WON       = 4'd8,
        LOST      = 4'd9
    } state_t;

    localparam logic [1:0] OUT_BLANK = 2'd0;
    localparam logic [1:0] OUT_MEM   = 2'd1;
    localparam logic [1:0] OUT_BTN   = 2'd2;

endpackage

// File: rtl/cakegame_uc.sv
// Moore control unit sequencing show/play/compare rounds of the cake game.
// Outputs decode from the state register only, so they follow inputs by one cycle; no backpressure.
module cakegame_uc
    import cakegame_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       mode_sw,
    input  logic       end_mem_counter,
    input  logic       correct_play,
    input  logic       has_play,
    input  logic       end_show,
    input  logic       half_show,
    input  logic       timeout,
    output logic [1:0] out_sel,
    output logic       dificuldade,
    output logic       clear_reg,
    output logic       enable_reg,
    output logic       clear_mem_counter,
    output logic       enable_mem_counter,
    output logic       clear_show_counter,
    output logic       enable_show_counter,
    output logic       enable_timeout_counter,
    output logic       clear_points_counter,
    output logic       enable_points_counter,
    output logic       won,
    output logic       lost,
    output logic       done,
    output logic [3:0] db_estado
);

    state_t r_state;
    state_t w_next;
    logic   r_dificuldade;
    logic   w_accept_start;

    // A start is only honoured from the resting states; that is also the only time difficulty is sampled.
    assign w_accept_start = start &&
                            ((r_state == IDLE) || (r_state == WON) || (r_state == LOST));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_dificuldade <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept_start) begin
                r_dificuldade <= mode_sw;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, WON, LOST: if (start) w_next = INIT;
            INIT:            w_next = SHOW;
            SHOW: begin
                if (end_show)       w_next = WAIT_PLAY;
                else if (half_show) w_next = SHOW_GAP;
            end
            SHOW_GAP:        if (end_show) w_next = WAIT_PLAY;
            WAIT_PLAY: begin
                if (has_play)     w_next = REGISTER;
                else if (timeout) w_next = LOST;
            end
            REGISTER:        w_next = COMPARE;
            COMPARE: begin
                if (!correct_play)       w_next = LOST;
                else if (end_mem_counter) w_next = WON;
                else                      w_next = NEXT;
            end
            NEXT:            w_next = SHOW;
            default:         w_next = IDLE;
        endcase
    end

    always_comb begin
        out_sel                = OUT_BLANK;
        clear_reg              = 1'b0;
        enable_reg             = 1'b0;
        clear_mem_counter      = 1'b0;
        enable_mem_counter     = 1'b0;
        clear_show_counter     = 1'b0;
        enable_show_counter    = 1'b0;
        enable_timeout_counter = 1'b0;
        clear_points_counter   = 1'b0;
        enable_points_counter  = 1'b0;
        won                    = 1'b0;
        lost                   = 1'b0;
        done                   = 1'b0;
        case (r_state)
            INIT: begin
                clear_reg            = 1'b1;
                clear_mem_counter    = 1'b1;
                clear_show_counter   = 1'b1;
                clear_points_counter = 1'b1;
            end
            SHOW: begin
                out_sel             = OUT_MEM;
                enable_show_counter = 1'b1;
            end
            SHOW_GAP:  enable_show_counter = 1'b1;
            WAIT_PLAY: begin
                out_sel                = OUT_BTN;
                enable_timeout_counter = 1'b1;
            end
            REGISTER: begin
                out_sel    = OUT_BTN;
                enable_reg = 1'b1;
            end
            COMPARE:   out_sel = OUT_BTN;
            // Scoring happens on the way to the next round, so the final winning round is never counted.
            NEXT: begin
                enable_points_counter = 1'b1;
                enable_mem_counter    = 1'b1;
                clear_show_counter    = 1'b1;
                clear_reg             = 1'b1;
            end
            WON: begin
                won  = 1'b1;
                done = 1'b1;
            end
            LOST: begin
                lost = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign dificuldade = r_dificuldade;
    assign db_estado   = r_state;

endmodule

// File: tb/tb_cakegame_uc.sv
// Directed-vector bench for cakegame_uc with hand-computed state and output expectations.
module tb_cakegame_uc;

    logic       clock = 1'b0;
    logic       reset, start, mode_sw, end_mem_counter, correct_play;
    logic       has_play, end_show, half_show, timeout;
    logic [1:0] out_sel;
    logic       dificuldade, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter;
    logic       clear_show_counter, enable_show_counter, enable_timeout_counter;
    logic       clear_points_counter, enable_points_counter, won, lost, done;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    cakegame_uc dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .mode_sw                (mode_sw),
        .end_mem_counter        (end_mem_counter),
        .correct_play           (correct_play),
        .has_play               (has_play),
        .end_show               (end_show),
        .half_show              (half_show),
        .timeout                (timeout),
        .out_sel                (out_sel),
        .dificuldade            (dificuldade),
        .clear_reg              (clear_reg),
        .enable_reg             (enable_reg),
        .clear_mem_counter      (clear_mem_counter),
        .enable_mem_counter     (enable_mem_counter),
        .clear_show_counter     (clear_show_counter),
        .enable_show_counter    (enable_show_counter),
        .enable_timeout_counter (enable_timeout_counter),
        .clear_points_counter   (clear_points_counter),
        .enable_points_counter  (enable_points_counter),
        .won                    (won),
        .lost                   (lost),
        .done                   (done),
        .db_estado              (db_estado)
    );

    // Bit order: out_sel[13:12] clr_reg en_reg clr_mem en_mem clr_show en_show en_to clr_pts en_pts won lost done
    wire [13:0] w_outs = {out_sel, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter,
                          clear_show_counter, enable_show_counter, enable_timeout_counter,
                          clear_points_counter, enable_points_counter, won, lost, done};

    localparam logic [13:0] O_IDLE  = 14'h0000;
    localparam logic [13:0] O_INIT  = 14'h0A90;
    localparam logic [13:0] O_SHOW  = 14'h1040;
    localparam logic [13:0] O_GAP   = 14'h0040;
    localparam logic [13:0] O_WAIT  = 14'h2020;
    localparam logic [13:0] O_REG   = 14'h2400;
    localparam logic [13:0] O_CMP   = 14'h2000;
    localparam logic [13:0] O_NEXT  = 14'h0988;
    localparam logic [13:0] O_WON   = 14'h0005;
    localparam logic [13:0] O_LOST  = 14'h0003;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then check state, decoded outputs and the difficulty latch.
    task automatic step_chk(input string tag, input logic [3:0] st, input logic [13:0] outs,
                            input logic dif);
        @(posedge clock);
        #1;
        check({tag, "/state"}, {12'd0, db_estado}, {12'd0, st});
        check({tag, "/outs"},  {2'd0, w_outs},     {2'd0, outs});
        check({tag, "/dif"},   {15'd0, dificuldade}, {15'd0, dif});
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; mode_sw = 1'b1; end_mem_counter = 1'b0;
        correct_play = 1'b0; has_play = 1'b0; end_show = 1'b0; half_show = 1'b0; timeout = 1'b0;

        // Reset wins over a pending start
        step_chk("rst0", 4'd0, O_IDLE, 1'b0);
        step_chk("rst1", 4'd0, O_IDLE, 1'b0);

        reset = 1'b0;
        step_chk("init", 4'd1, O_INIT, 1'b1);
        start = 1'b0; mode_sw = 1'b0;
        step_chk("show", 4'd2, O_SHOW, 1'b1);
        step_chk("show_hold", 4'd2, O_SHOW, 1'b1);
        half_show = 1'b1;
        step_chk("gap", 4'd3, O_GAP, 1'b1);
        half_show = 1'b0;
        step_chk("gap_hold", 4'd3, O_GAP, 1'b1);
        end_show = 1'b1;
        step_chk("wait", 4'd4, O_WAIT, 1'b1);
        end_show = 1'b0;
        step_chk("wait_hold", 4'd4, O_WAIT, 1'b1);

        has_play = 1'b1;
        step_chk("reg", 4'd5, O_REG, 1'b1);
        has_play = 1'b0; correct_play = 1'b1;
        step_chk("cmp", 4'd6, O_CMP, 1'b1);
        step_chk("next", 4'd7, O_NEXT, 1'b1);
        correct_play = 1'b0;
        step_chk("show2", 4'd2, O_SHOW, 1'b1);

        // end_show beats half_show in SHOW; has_play beats timeout
        end_show = 1'b1; half_show = 1'b1;
        step_chk("wait2", 4'd4, O_WAIT, 1'b1);
        end_show = 1'b0; half_show = 1'b0;
        has_play = 1'b1; timeout = 1'b1;
        step_chk("reg_race", 4'd5, O_REG, 1'b1);
        has_play = 1'b0; timeout = 1'b0; mode_sw = 1'b0;
        step_chk("cmp2", 4'd6, O_CMP, 1'b1);
        correct_play = 1'b1; end_mem_counter = 1'b1; mode_sw = 1'b1; start = 1'b0;
        step_chk("won", 4'd8, O_WON, 1'b1);
        correct_play = 1'b0; end_mem_counter = 1'b0; mode_sw = 1'b0;
        step_chk("won_hold", 4'd8, O_WON, 1'b1);
        start = 1'b1;
        step_chk("reinit", 4'd1, O_INIT, 1'b0);
        start = 1'b0; mode_sw = 1'b1;
        step_chk("show3", 4'd2, O_SHOW, 1'b0);

        end_show = 1'b1;
        step_chk("wait3", 4'd4, O_WAIT, 1'b0);
        end_show = 1'b0; timeout = 1'b1;
        step_chk("lost_to", 4'd9, O_LOST, 1'b0);
        timeout = 1'b0;
        step_chk("lost_hold", 4'd9, O_LOST, 1'b0);
        start = 1'b1; mode_sw = 1'b1;
        step_chk("reinit2", 4'd1, O_INIT, 1'b1);
        start = 1'b0;
        step_chk("show4", 4'd2, O_SHOW, 1'b1);
        end_show = 1'b1;
        step_chk("wait4", 4'd4, O_WAIT, 1'b1);
        end_show = 1'b0; has_play = 1'b1;
        step_chk("reg4", 4'd5, O_REG, 1'b1);
        has_play = 1'b0; correct_play = 1'b0; end_mem_counter = 1'b1;
        step_chk("cmp4", 4'd6, O_CMP, 1'b1);
        step_chk("lost_cmp", 4'd9, O_LOST, 1'b1);
        end_mem_counter = 1'b0;

        start = 1'b1;
        step_chk("reinit3", 4'd1, O_INIT, 1'b1);
        start = 1'b0;
        step_chk("show5", 4'd2, O_SHOW, 1'b1);
        end_show = 1'b1;
        step_chk("wait5", 4'd4, O_WAIT, 1'b1);
        end_show = 1'b0; has_play = 1'b1; reset = 1'b1;
        step_chk("rst_mid", 4'd0, O_IDLE, 1'b0);
        has_play = 1'b0; reset = 1'b0;
        step_chk("idle_hold", 4'd0, O_IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
